// File: rtl/search_scheduler_if.sv
// Request, engine and response signal bundle for the search scheduler.
// The slave view belongs to the scheduler; the master view belongs to its surroundings.
interface search_scheduler_if #(
  parameter int unsigned number_size = 8,
  parameter int unsigned index_size  = 4,
  parameter int unsigned tag_size    = 2
);
  logic                   req_valid;
  logic                   req_ready;
  logic [number_size-1:0] req_target;
  logic [tag_size-1:0]    req_tag;

  logic                   eng_start;
  logic [number_size-1:0] eng_target;
  logic                   eng_abort;
  logic                   eng_done;
  logic [index_size-1:0]  eng_result;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [index_size-1:0]  rsp_index;
  logic [tag_size-1:0]    rsp_tag;
  logic                   rsp_timeout;

  logic                   busy;

  modport slave (
    input  req_valid, req_target, req_tag, eng_done, eng_result, rsp_ready,
    output req_ready, eng_start, eng_target, eng_abort,
           rsp_valid, rsp_index, rsp_tag, rsp_timeout, busy
  );

  modport master (
    output req_valid, req_target, req_tag, eng_done, eng_result, rsp_ready,
    input  req_ready, eng_start, eng_target, eng_abort,
           rsp_valid, rsp_index, rsp_tag, rsp_timeout, busy
  );
endinterface

// File: rtl/search_scheduler.sv
// Job queue and sequencer in front of one binary-search engine: one job in flight,
// watchdog on the engine's done, results returned in request order with their tag.
module search_scheduler #(
  parameter int unsigned number_size    = 8,
  parameter int unsigned index_size     = 4,
  parameter int unsigned tag_size       = 2,
  parameter int unsigned fifo_depth     = 4,
  parameter int unsigned timeout_cycles = 255
) (
  input logic               clk,
  input logic               rst,
  search_scheduler_if.slave bus
);

  localparam int unsigned ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int unsigned cnt_w = $clog2(fifo_depth) + 1;
  localparam int unsigned tmr_w = (timeout_cycles > 1) ? $clog2(timeout_cycles + 1) : 1;

  localparam logic [cnt_w-1:0]      full_cnt  = cnt_w'(fifo_depth);
  localparam logic [tmr_w-1:0]      tmr_last  = tmr_w'(timeout_cycles - 1);
  localparam logic [index_size-1:0] not_found = '1;

  typedef enum logic [1:0] {
    st_idle,
    st_launch,
    st_wait,
    st_resp
  } state_t;

  typedef struct packed {
    logic [number_size-1:0] target;
    logic [tag_size-1:0]    tag;
  } job_t;

  state_t state, state_next;

  job_t             mem [fifo_depth];
  logic [ptr_w-1:0] wr_ptr, wr_ptr_next;
  logic [ptr_w-1:0] rd_ptr, rd_ptr_next;
  logic [cnt_w-1:0] count, count_next;
  logic [tmr_w-1:0] timer, timer_next;

  logic                   push;
  logic                   pop;
  logic                   ready_next;
  logic                   busy_next;
  logic                   start_next;
  logic                   abort_next;
  logic [number_size-1:0] target_next;
  logic [tag_size-1:0]    tag_next;
  logic                   rsp_valid_next;
  logic [index_size-1:0]  rsp_index_next;
  logic                   rsp_timeout_next;

  assign push = bus.req_valid && bus.req_ready;

  // Job sequencing; pop happens only when leaving idle
  always_comb begin
    state_next       = state;
    pop              = 1'b0;
    timer_next       = timer;
    start_next       = 1'b0;
    abort_next       = 1'b0;
    target_next      = bus.eng_target;
    tag_next         = bus.rsp_tag;
    rsp_valid_next   = bus.rsp_valid;
    rsp_index_next   = bus.rsp_index;
    rsp_timeout_next = bus.rsp_timeout;

    unique case (state)
      st_idle: begin
        if (count != '0) begin
          pop         = 1'b1;
          target_next = mem[rd_ptr].target;
          tag_next    = mem[rd_ptr].tag;
          start_next  = 1'b1;
          state_next  = st_launch;
        end
      end
      st_launch: begin
        timer_next = '0;
        state_next = st_wait;
      end
      st_wait: begin
        // done outranks a watchdog expiry landing in the same cycle
        if (bus.eng_done) begin
          rsp_index_next   = bus.eng_result;
          rsp_timeout_next = 1'b0;
          rsp_valid_next   = 1'b1;
          state_next       = st_resp;
        end else if (timer == tmr_last) begin
          rsp_index_next   = not_found;
          rsp_timeout_next = 1'b1;
          rsp_valid_next   = 1'b1;
          abort_next       = 1'b1;
          state_next       = st_resp;
        end else begin
          timer_next = timer + tmr_w'(1);
        end
      end
      st_resp: begin
        if (bus.rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = st_idle;
        end
      end
      default: state_next = st_idle;
    endcase
  end

  // FIFO bookkeeping
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    if (push) begin
      wr_ptr_next = wr_ptr + ptr_w'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr + ptr_w'(1);
    end
    unique case ({push, pop})
      2'b10:   count_next = count + cnt_w'(1);
      2'b01:   count_next = count - cnt_w'(1);
      default: count_next = count;
    endcase
    ready_next = (count_next != full_cnt);
    busy_next  = (state_next != st_idle) || (count_next != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= st_idle;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= job_t'({bus.req_target, bus.req_tag});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      timer           <= '0;
      bus.req_ready   <= 1'b1;
      bus.busy        <= 1'b0;
      bus.eng_start   <= 1'b0;
      bus.eng_abort   <= 1'b0;
      bus.eng_target  <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_index   <= '0;
      bus.rsp_tag     <= '0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      wr_ptr          <= wr_ptr_next;
      rd_ptr          <= rd_ptr_next;
      count           <= count_next;
      timer           <= timer_next;
      bus.req_ready   <= ready_next;
      bus.busy        <= busy_next;
      bus.eng_start   <= start_next;
      bus.eng_abort   <= abort_next;
      bus.eng_target  <= target_next;
      bus.rsp_valid   <= rsp_valid_next;
      bus.rsp_index   <= rsp_index_next;
      bus.rsp_tag     <= tag_next;
      bus.rsp_timeout <= rsp_timeout_next;
    end
  end

endmodule

// File: tb/tb_search_scheduler.sv
// Directed bench for search_scheduler: an engine model answers eng_start after a
// programmable delay and a scoreboard checks every accepted response in order.
module tb_search_scheduler;

  typedef struct packed {
    logic [3:0] idx;
    logic [1:0] tag;
    logic       to;
  } exp_t;

  logic clk;
  logic rst;

  search_scheduler_if #(.number_size(8), .index_size(4), .tag_size(2)) bus ();

  search_scheduler #(
    .number_size(8), .index_size(4), .tag_size(2),
    .fifo_depth(4), .timeout_cycles(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   total = 0;
  int   bad = 0;
  int   starts = 0;
  int   aborts = 0;
  int   eng_delay = -1;
  exp_t sb[$];
  exp_t mon_e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [7:0] tgt, input logic [1:0] tag, input bit to);
    exp_t e;
    e.idx = to ? 4'hF : ~tgt[3:0];
    e.tag = tag;
    e.to  = to;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Engine model: done with result ~target[3:0] 'eng_delay' cycles after the start cycle
  initial begin
    int  left;
    bit  armed;
    logic [3:0] res;
    armed = 1'b0;
    left = 0;
    res = '0;
    bus.eng_done = 1'b0;
    bus.eng_result = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.eng_done = 1'b0;
      bus.eng_result = 4'($urandom);
      if (!rst) begin
        armed = 1'b0;
      end else if (bus.eng_start) begin
        armed = (eng_delay > 0);
        left  = eng_delay;
        res   = ~bus.eng_target[3:0];
      end else if (armed) begin
        left--;
        if (left == 0) begin
          bus.eng_done   = 1'b1;
          bus.eng_result = res;
          armed = 1'b0;
        end
      end
    end
  end

  // Response scoreboard and pulse counters
  always @(negedge clk) begin
    if (rst) begin
      if (bus.eng_start) starts++;
      if (bus.eng_abort) aborts++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        check("rsp_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("rsp_index", 32'(bus.rsp_index), 32'(mon_e.idx));
          check("rsp_tag", 32'(bus.rsp_tag), 32'(mon_e.tag));
          check("rsp_timeout", 32'(bus.rsp_timeout), 32'(mon_e.to));
        end
      end
    end
  end

  task automatic push(input logic [7:0] tgt, input logic [1:0] tag, input bit to);
    int n;
    n = 0;
    bus.req_valid  = 1'b1;
    bus.req_target = tgt;
    bus.req_tag    = tag;
    while (!bus.req_ready && n < 60) begin
      tick();
      n++;
    end
    check("push_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    sb.push_back(mk_exp(tgt, tag, to));
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!bus.eng_start && n < 60) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.eng_start), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_eng_start"}, 32'(bus.eng_start), 32'd0);
    check({tag, "_eng_abort"}, 32'(bus.eng_abort), 32'd0);
    check({tag, "_eng_target"}, 32'(bus.eng_target), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_index"}, 32'(bus.rsp_index), 32'd0);
    check({tag, "_rsp_tag"}, 32'(bus.rsp_tag), 32'd0);
    check({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
  endtask

  initial begin
    int s0;
    int a0;
    int n;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_target = '0;
    bus.req_tag = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Single job with exact latency checks
    eng_delay = 3;
    push(8'h2A, 2'd1, 1'b0);
    check("t1_no_start_yet", 32'(bus.eng_start), 32'd0);
    check("t1_busy", 32'(bus.busy), 32'd1);
    tick();
    check("t1_start", 32'(bus.eng_start), 32'd1);
    check("t1_target", 32'(bus.eng_target), 32'h2A);
    tick();
    check("t1_start_pulse", 32'(bus.eng_start), 32'd0);
    tick();
    tick();
    check("t1_target_hold", 32'(bus.eng_target), 32'h2A);
    check("t1_no_rsp_yet", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("t1_rsp_index", 32'(bus.rsp_index), 32'd5);
    check("t1_rsp_tag", 32'(bus.rsp_tag), 32'd1);
    check("t1_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    bus.rsp_ready = 1'b1;
    drain("t1_drain");
    check("t1_starts", 32'(starts), 32'd1);

    // Back-to-back pushes until full, then one more once space frees
    s0 = starts;
    a0 = aborts;
    push(8'h11, 2'd0, 1'b0);
    push(8'h12, 2'd1, 1'b0);
    push(8'h13, 2'd2, 1'b0);
    push(8'h14, 2'd3, 1'b0);
    check("t2_ready_after4", 32'(bus.req_ready), 32'd1);
    push(8'h15, 2'd0, 1'b0);
    check("t2_full", 32'(bus.req_ready), 32'd0);
    push(8'h16, 2'd1, 1'b0);
    drain("t2_drain");
    check("t2_starts", 32'(starts - s0), 32'd6);
    check("t2_no_abort", 32'(aborts - a0), 32'd0);

    // Watchdog expiry with no done at all
    eng_delay = -1;
    a0 = aborts;
    push(8'h47, 2'd2, 1'b1);
    wait_start("t3_start");
    n = 0;
    while (!bus.eng_abort && n < 30) begin
      tick();
      n++;
    end
    check("t3_abort_delay", 32'(n), 32'd9);
    check("t3_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("t3_rsp_index", 32'(bus.rsp_index), 32'hF);
    check("t3_rsp_timeout", 32'(bus.rsp_timeout), 32'd1);
    tick();
    check("t3_abort_pulse", 32'(bus.eng_abort), 32'd0);
    drain("t3_drain");
    check("t3_abort_count", 32'(aborts - a0), 32'd1);

    // Done on the expiry cycle and one cycle before it
    eng_delay = 8;
    a0 = aborts;
    push(8'h5C, 2'd3, 1'b0);
    drain("t4a_drain");
    eng_delay = 7;
    push(8'h6E, 2'd0, 1'b0);
    drain("t4b_drain");
    check("t4_no_abort", 32'(aborts - a0), 32'd0);

    // Response backpressure
    eng_delay = 3;
    bus.rsp_ready = 1'b0;
    push(8'h31, 2'd2, 1'b0);
    n = 0;
    while (!bus.rsp_valid && n < 30) begin
      tick();
      n++;
    end
    check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    s0 = starts;
    push(8'h32, 2'd3, 1'b0);
    push(8'h33, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("t5_hold_index", 32'(bus.rsp_index), 32'(sb[0].idx));
      check("t5_hold_tag", 32'(bus.rsp_tag), 32'(sb[0].tag));
      check("t5_hold_timeout", 32'(bus.rsp_timeout), 32'(sb[0].to));
      tick();
    end
    check("t5_no_start", 32'(starts - s0), 32'd0);
    push(8'h34, 2'd1, 1'b0);
    push(8'h35, 2'd2, 1'b0);
    check("t5_fifo_full", 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    drain("t5_drain");

    // Asynchronous reset during WAIT with two jobs queued
    eng_delay = -1;
    push(8'h71, 2'd0, 1'b1);
    push(8'h72, 2'd1, 1'b1);
    push(8'h73, 2'd2, 1'b1);
    tick();
    check("t6_in_flight", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    sb.delete();
    s0 = starts;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (20) tick();
    check("t6_no_start", 32'(starts - s0), 32'd0);
    check("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
    check("t6_idle", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
